ex: RTL
=======

# ex

Execute stage of the five-stage MIPS pipeline. Consumes the decoded operation, operands and write-back tag registered by the ID/EX pipeline register, and produces the GPR write-back result for the EX/MEM register. Owns the HI/LO register pair and a 32-cycle iterative divider, and requests a pipeline stall while a division is in progress.

## Interface
- No parameters.
- ex_clk  in  1  clock; all state updates on the rising edge.
- ex_rst  in  1  synchronous reset, active-high.
- ex_aluop_i  in  8  bit 7 selects operand B: 1 = ex_ext_imm_i, 0 = ex_rdata_2_i; bits 6:0 give the operation code (see Operation).
- ex_alusel_i  in  3  operation class: 001 logic, 010 shift, 011 arith, 100 move, 101 muldiv, others NOP.
- ex_rdata_1_i  in  32  operand A (rs).
- ex_rdata_2_i  in  32  rt value; shift source.
- ex_ext_imm_i  in  32  extended immediate; bits 4:0 also carry the shift amount.
- ex_waddr_i  in  5  destination GPR.
- ex_we_i  in  1  GPR write enable from decode.
- ex_wdata_o  out  32  GPR result (combinational).
- ex_waddr_o  out  5  equals ex_waddr_i.
- ex_we_o  out  1  GPR write enable to EX/MEM.
- ex_stall_req_o  out  1  hold request to pipeline control.
- ex_hi_o  out  32  current HI register.
- ex_lo_o  out  32  current LO register.

## Operation
- B = ex_aluop_i[7] ? ex_ext_imm_i : ex_rdata_2_i; sa = ex_ext_imm_i[4:0].
- Logic: 0x01 AND, 0x02 OR, 0x03 XOR, 0x04 NOR, 0x05 LUI ({B[15:0],16'h0}).
- Shift (source ex_rdata_2_i by sa): 0x10 SLL, 0x11 SRL, 0x12 SRA.
- Arith: 0x20 ADDU, 0x21 SUBU (mod 2^32, no overflow trap), 0x22 SLT (signed, result 0/1), 0x23 SLTU.
- Move: 0x30 MFHI, 0x31 MFLO (result = HI/LO); 0x32 MTHI, 0x33 MTLO (HI/LO <= A at clock edge).
- Muldiv: 0x40 MULT, 0x41 MULTU: 64-bit product of A and B; {HI,LO} written at the clock edge, single cycle. 0x42 DIV, 0x43 DIVU: LO <= quotient, HI <= remainder.
- Unknown code, or alusel NOP: ex_wdata_o = 0 and ex_we_o = 0.
- ex_we_o = ex_we_i & ~ex_stall_req_o, forced 0 for MTHI/MTLO/MULT*/DIV*.
- Divider FSM, states IDLE, BUSY, DONE; 5-bit iteration counter.
  - IDLE + DIV/DIVU, divisor != 0: latch operand magnitudes (signed DIV uses absolute values), counter <= 0, go to BUSY.
  - IDLE + divisor == 0: go to DONE and mark the result invalid.
  - BUSY: one restoring shift-subtract step per cycle. After the step with counter == 31, go to DONE.
  - DONE: if the result is valid, write HI/LO. Signed fix-up: the quotient is negated when operand signs differ; the remainder takes the dividend's sign. Then go to IDLE.
- ex_stall_req_o = 1 whenever a DIV/DIVU is presented and the FSM is not in DONE. Pipeline control holds the ID/EX inputs stable while the stall is asserted.

## Timing
- Reset: HI = LO = 0, FSM = IDLE, counter = 0. While ex_rst = 1: ex_wdata_o = 0, ex_we_o = 0, ex_stall_req_o = 0.
- All non-divide operations: 0-cycle combinational result. HI/LO writes are visible to an MFHI/MFLO in the next cycle.
- DIV, divisor != 0: cycle 0 is IDLE, cycles 1–32 are BUSY, cycle 33 is DONE. Stall is high for cycles 0–32 (33 cycles). HI/LO update at the end of cycle 33.
- DIV, divisor == 0: stall high for cycle 0 only; HI/LO unchanged.
- Reset mid-divide: FSM returns to IDLE and HI/LO are cleared on that edge. Stall is low from the next cycle. The partial result is discarded.
- MTHI/MTLO/MULT while the FSM is not IDLE cannot occur, because the pipeline is stalled.

## Test plan
- ADDU, A = 0x7FFFFFFF, aluop = 0xA0 with imm = 0x00000001 -> ex_wdata_o = 0x80000000, ex_we_o = ex_we_i.
- SRA, rdata_2 = 0x80000000, sa = 4 -> 0xF8000000. SLT, A = 0xFFFFFFFF, B = 1 -> 1. SLTU with the same operands -> 0.
- MULT A = 0xFFFFFFFE, B = 3 -> HI = 0xFFFFFFFF, LO = 0xFFFFFFFA. MFHI in the next cycle -> 0xFFFFFFFF with we = 1.
- DIV A = 0xFFFFFFF9 (−7), B = 2 -> stall 33 cycles, then LO = 0xFFFFFFFD, HI = 0xFFFFFFFF, ex_we_o = 0 throughout. DIVU 100/7 -> LO = 14, HI = 2.
- DIV with B = 0, HI/LO preloaded 0x11111111/0x22222222 via MTHI/MTLO -> stall exactly 1 cycle, HI/LO unchanged.
- Reset asserted during BUSY cycle 10 -> stall low from the next cycle, HI = LO = 0. A following ADDU 2 + 3 -> 5.

Source files
------------

// File: rtl/ex_if.sv
// Bundle between the ID/EX pipeline register, the execute stage and EX/MEM.
// master: drives the decoded operation into the execute stage and consumes
//         its results (pipeline side / testbench).
// slave:  the execute stage itself.
// ex_div_state_o exposes the divider FSM state for observation.
interface ex_if;
  logic [7:0]  ex_aluop_i;
  logic [2:0]  ex_alusel_i;
  logic [31:0] ex_rdata_1_i;
  logic [31:0] ex_rdata_2_i;
  logic [31:0] ex_ext_imm_i;
  logic [4:0]  ex_waddr_i;
  logic        ex_we_i;
  logic [31:0] ex_wdata_o;
  logic [4:0]  ex_waddr_o;
  logic        ex_we_o;
  logic        ex_stall_req_o;
  logic [31:0] ex_hi_o;
  logic [31:0] ex_lo_o;
  logic [1:0]  ex_div_state_o;

  modport master (
    output ex_aluop_i, ex_alusel_i, ex_rdata_1_i, ex_rdata_2_i,
           ex_ext_imm_i, ex_waddr_i, ex_we_i,
    input  ex_wdata_o, ex_waddr_o, ex_we_o, ex_stall_req_o,
           ex_hi_o, ex_lo_o, ex_div_state_o
  );

  modport slave (
    input  ex_aluop_i, ex_alusel_i, ex_rdata_1_i, ex_rdata_2_i,
           ex_ext_imm_i, ex_waddr_i, ex_we_i,
    output ex_wdata_o, ex_waddr_o, ex_we_o, ex_stall_req_o,
           ex_hi_o, ex_lo_o, ex_div_state_o
  );
endinterface

// File: rtl/ex.sv
// Execute stage: combinational ALU for logic/shift/arith/move ops, HI/LO
// register pair, single-cycle multiply and a 32-step restoring divider that
// holds the pipeline (stall request) until its result is ready.
//
// Stall handshake: ex_stall_req_o is high while a DIV/DIVU is presented and
// the divider has not reached DONE; the pipeline holds the ID/EX inputs
// stable for every cycle the request is high, and the divide completes in
// the first cycle it is low.
module ex (
  input  logic ex_clk,
  input  logic ex_rst,
  ex_if.slave  bus
);

  localparam logic [2:0] SEL_LOGIC  = 3'b001;
  localparam logic [2:0] SEL_SHIFT  = 3'b010;
  localparam logic [2:0] SEL_ARITH  = 3'b011;
  localparam logic [2:0] SEL_MOVE   = 3'b100;
  localparam logic [2:0] SEL_MULDIV = 3'b101;

  localparam logic [6:0] OP_AND   = 7'h01;
  localparam logic [6:0] OP_OR    = 7'h02;
  localparam logic [6:0] OP_XOR   = 7'h03;
  localparam logic [6:0] OP_NOR   = 7'h04;
  localparam logic [6:0] OP_LUI   = 7'h05;
  localparam logic [6:0] OP_SLL   = 7'h10;
  localparam logic [6:0] OP_SRL   = 7'h11;
  localparam logic [6:0] OP_SRA   = 7'h12;
  localparam logic [6:0] OP_ADDU  = 7'h20;
  localparam logic [6:0] OP_SUBU  = 7'h21;
  localparam logic [6:0] OP_SLT   = 7'h22;
  localparam logic [6:0] OP_SLTU  = 7'h23;
  localparam logic [6:0] OP_MFHI  = 7'h30;
  localparam logic [6:0] OP_MFLO  = 7'h31;
  localparam logic [6:0] OP_MTHI  = 7'h32;
  localparam logic [6:0] OP_MTLO  = 7'h33;
  localparam logic [6:0] OP_MULT  = 7'h40;
  localparam logic [6:0] OP_MULTU = 7'h41;
  localparam logic [6:0] OP_DIV   = 7'h42;
  localparam logic [6:0] OP_DIVU  = 7'h43;

  typedef enum logic [1:0] {
    DIV_IDLE = 2'd0,
    DIV_BUSY = 2'd1,
    DIV_DONE = 2'd2
  } div_state_t;

  div_state_t  state, state_nxt;

  logic [6:0]  op;
  logic [31:0] opa, opb;
  logic [4:0]  sa;
  logic [31:0] hi, lo;

  logic        is_div, is_div_signed, divisor_zero;
  logic        div_start, div_step, div_commit;
  logic        stall;

  logic [4:0]  cnt;
  logic [31:0] rem, quo, dvsr;
  logic        neg_q, neg_r, div_valid;
  logic [31:0] a_mag, b_mag;
  logic [32:0] shifted;
  logic [33:0] diff;
  logic        ge;
  logic [31:0] q_fix, r_fix;

  logic signed [63:0] sa64, sb64;
  logic [63:0] prod_s, prod_u;

  logic [31:0] result;
  logic        has_result;

  assign op  = bus.ex_aluop_i[6:0];
  assign opa = bus.ex_rdata_1_i;
  assign opb = bus.ex_aluop_i[7] ? bus.ex_ext_imm_i : bus.ex_rdata_2_i;
  assign sa  = bus.ex_ext_imm_i[4:0];

  assign is_div        = (bus.ex_alusel_i == SEL_MULDIV) && ((op == OP_DIV) || (op == OP_DIVU));
  assign is_div_signed = (op == OP_DIV);
  assign divisor_zero  = (opb == 32'd0);

  // Magnitudes for the unsigned core; signed DIV divides absolute values.
  assign a_mag = (is_div_signed && opa[31]) ? (32'd0 - opa) : opa;
  assign b_mag = (is_div_signed && opb[31]) ? (32'd0 - opb) : opb;

  // One restoring step: shift next dividend bit in, subtract if it fits.
  assign shifted = {rem, quo[31]};
  assign diff    = {1'b0, shifted} - {2'b00, dvsr};
  assign ge      = ~diff[33];

  assign q_fix = neg_q ? (32'd0 - quo) : quo;
  assign r_fix = neg_r ? (32'd0 - rem) : rem;

  assign sa64   = {{32{opa[31]}}, opa};
  assign sb64   = {{32{opb[31]}}, opb};
  assign prod_s = sa64 * sb64;
  assign prod_u = {32'd0, opa} * {32'd0, opb};

  // Divider FSM state register.
  always_ff @(posedge ex_clk) begin
    if (ex_rst) state <= DIV_IDLE;
    else        state <= state_nxt;
  end

  // Divider FSM next-state logic.
  always_comb begin
    state_nxt = state;
    case (state)
      DIV_IDLE: if (is_div) state_nxt = divisor_zero ? DIV_DONE : DIV_BUSY;
      DIV_BUSY: if (cnt == 5'd31) state_nxt = DIV_DONE;
      DIV_DONE: state_nxt = DIV_IDLE;
      default:  state_nxt = DIV_IDLE;
    endcase
  end

  // Divider FSM outputs: stall request and datapath strobes.
  always_comb begin
    stall      = 1'b0;
    div_start  = 1'b0;
    div_step   = 1'b0;
    div_commit = 1'b0;
    if (!ex_rst) begin
      stall      = is_div && (state != DIV_DONE);
      div_start  = is_div && (state == DIV_IDLE);
      div_step   = (state == DIV_BUSY);
      div_commit = (state == DIV_DONE) && div_valid;
    end
  end

  // Divider datapath: operand latch, iteration counter and shift-subtract.
  always_ff @(posedge ex_clk) begin
    if (ex_rst) begin
      cnt       <= 5'd0;
      rem       <= 32'd0;
      quo       <= 32'd0;
      dvsr      <= 32'd0;
      neg_q     <= 1'b0;
      neg_r     <= 1'b0;
      div_valid <= 1'b0;
    end else if (div_start) begin
      div_valid <= ~divisor_zero;
      if (!divisor_zero) begin
        cnt   <= 5'd0;
        rem   <= 32'd0;
        quo   <= a_mag;
        dvsr  <= b_mag;
        neg_q <= is_div_signed && (opa[31] ^ opb[31]);
        neg_r <= is_div_signed && opa[31];
      end
    end else if (div_step) begin
      rem <= ge ? diff[31:0] : shifted[31:0];
      quo <= {quo[30:0], ge};
      cnt <= cnt + 5'd1;
    end
  end

  // HI/LO register pair: divide commit, multiply, or explicit move.
  always_ff @(posedge ex_clk) begin
    if (ex_rst) begin
      hi <= 32'd0;
      lo <= 32'd0;
    end else if (div_commit) begin
      hi <= r_fix;
      lo <= q_fix;
    end else if (bus.ex_alusel_i == SEL_MULDIV && op == OP_MULT) begin
      hi <= prod_s[63:32];
      lo <= prod_s[31:0];
    end else if (bus.ex_alusel_i == SEL_MULDIV && op == OP_MULTU) begin
      hi <= prod_u[63:32];
      lo <= prod_u[31:0];
    end else if (bus.ex_alusel_i == SEL_MOVE && op == OP_MTHI) begin
      hi <= opa;
    end else if (bus.ex_alusel_i == SEL_MOVE && op == OP_MTLO) begin
      lo <= opa;
    end
  end

  // GPR result mux; has_result marks ops that write a GPR.
  always_comb begin
    result     = 32'd0;
    has_result = 1'b0;
    case (bus.ex_alusel_i)
      SEL_LOGIC: begin
        has_result = 1'b1;
        case (op)
          OP_AND:  result = opa & opb;
          OP_OR:   result = opa | opb;
          OP_XOR:  result = opa ^ opb;
          OP_NOR:  result = ~(opa | opb);
          OP_LUI:  result = {opb[15:0], 16'h0000};
          default: has_result = 1'b0;
        endcase
      end
      SEL_SHIFT: begin
        has_result = 1'b1;
        case (op)
          OP_SLL:  result = bus.ex_rdata_2_i << sa;
          OP_SRL:  result = bus.ex_rdata_2_i >> sa;
          OP_SRA:  result = 32'($signed(bus.ex_rdata_2_i) >>> sa);
          default: has_result = 1'b0;
        endcase
      end
      SEL_ARITH: begin
        has_result = 1'b1;
        case (op)
          OP_ADDU: result = opa + opb;
          OP_SUBU: result = opa - opb;
          OP_SLT:  result = {31'd0, ($signed(opa) < $signed(opb))};
          OP_SLTU: result = {31'd0, (opa < opb)};
          default: has_result = 1'b0;
        endcase
      end
      SEL_MOVE: begin
        case (op)
          OP_MFHI: begin result = hi; has_result = 1'b1; end
          OP_MFLO: begin result = lo; has_result = 1'b1; end
          default: has_result = 1'b0;
        endcase
      end
      default: has_result = 1'b0;
    endcase
  end

  assign bus.ex_wdata_o     = ex_rst ? 32'd0 : result;
  assign bus.ex_waddr_o     = bus.ex_waddr_i;
  assign bus.ex_we_o        = ~ex_rst & bus.ex_we_i & ~stall & has_result;
  assign bus.ex_stall_req_o = stall;
  assign bus.ex_hi_o        = hi;
  assign bus.ex_lo_o        = lo;
  assign bus.ex_div_state_o = state;

endmodule
